// File: rtl/door_lock_controller_if.sv
// Keypad, door-sensor and lock/alarm signals between the lock controller and its surroundings.
// The master drives the keypad and door inputs; the slave (the controller) drives the lock and status outputs.
interface door_lock_controller_if;
  logic       key_valid;
  logic [3:0] key_digit;
  logic       lock_cmd;
  logic       magnetic_sensor;
  logic       door_alarm;
  logic       locked;
  logic       siren;
  logic       lockout;
  logic       unlock_ok;
  logic       attempt_fail;

  modport master (
    output key_valid, key_digit, lock_cmd, magnetic_sensor, door_alarm,
    input  locked, siren, lockout, unlock_ok, attempt_fail
  );

  modport slave (
    input  key_valid, key_digit, lock_cmd, magnetic_sensor, door_alarm,
    output locked, siren, lockout, unlock_ok, attempt_fail
  );
endinterface

// File: rtl/door_lock_controller.sv
// Keypad lock controller: code entry, auto/manual re-lock, wrong-code lockout, latched siren.
// Code result visible one cycle after the final strobe; no backpressure, strobes outside LOCKED/ALARM are dropped.
module door_lock_controller #(
  parameter int                      CODE_DIGITS    = 4,
  parameter logic [4*CODE_DIGITS-1:0] SECRET        = 16'h1234,
  parameter int                      MAX_FAILS      = 3,
  parameter int                      LOCKOUT_CYCLES = 16,
  parameter int                      AUTO_RELOCK    = 20,
  parameter int                      ENTRY_TIMEOUT  = 10
) (
  input logic                    clk,
  input logic                    reset,
  door_lock_controller_if.slave  io
);

  localparam int BW = 4 * CODE_DIGITS;
  localparam int CW = $clog2(CODE_DIGITS + 1);
  localparam int FW = $clog2(MAX_FAILS + 1);
  localparam int LW = $clog2(LOCKOUT_CYCLES + 1);
  localparam int RW = $clog2(AUTO_RELOCK + 1);
  localparam int IW = $clog2(ENTRY_TIMEOUT + 1);

  typedef enum logic [1:0] {
    ST_LOCKED   = 2'd0,
    ST_UNLOCKED = 2'd1,
    ST_LOCKOUT  = 2'd2,
    ST_ALARM    = 2'd3
  } state_t;

  state_t        state_q, state_d;
  logic [BW-1:0] buf_q, buf_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [IW-1:0] idle_q, idle_d;
  logic [FW-1:0] fails_q, fails_d;
  logic [LW-1:0] lkout_q, lkout_d;
  logic [RW-1:0] relock_q, relock_d;
  logic          unlock_ok_q, unlock_ok_d;
  logic          attempt_fail_q, attempt_fail_d;

  logic          entry_ok;
  logic          key_take;
  logic          last_digit;
  logic          code_done;
  logic          code_match;
  logic [BW-1:0] code_word;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q        <= ST_LOCKED;
      buf_q          <= '0;
      cnt_q          <= '0;
      idle_q         <= '0;
      fails_q        <= '0;
      lkout_q        <= '0;
      relock_q       <= '0;
      unlock_ok_q    <= 1'b0;
      attempt_fail_q <= 1'b0;
    end else begin
      state_q        <= state_d;
      buf_q          <= buf_d;
      cnt_q          <= cnt_d;
      idle_q         <= idle_d;
      fails_q        <= fails_d;
      lkout_q        <= lkout_d;
      relock_q       <= relock_d;
      unlock_ok_q    <= unlock_ok_d;
      attempt_fail_q <= attempt_fail_d;
    end
  end

  always_comb begin
    state_d        = state_q;
    buf_d          = buf_q;
    cnt_d          = cnt_q;
    idle_d         = idle_q;
    fails_d        = fails_q;
    lkout_d        = lkout_q;
    relock_d       = relock_q;
    unlock_ok_d    = 1'b0;
    attempt_fail_d = 1'b0;

    entry_ok   = (state_q == ST_LOCKED) || (state_q == ST_ALARM);
    key_take   = entry_ok && io.key_valid;
    code_word  = (buf_q << 4) | BW'(io.key_digit);
    last_digit = (cnt_q == CW'(CODE_DIGITS - 1));
    code_done  = key_take && last_digit;
    code_match = (code_word == SECRET);

    // Digit collection; a completed code always leaves the buffer empty.
    if (key_take) begin
      idle_d = '0;
      if (last_digit) begin
        buf_d = '0;
        cnt_d = '0;
      end else begin
        buf_d = code_word;
        cnt_d = cnt_q + CW'(1);
      end
    end else if (entry_ok && (cnt_q != '0)) begin
      if (idle_q >= IW'(ENTRY_TIMEOUT - 1)) begin
        buf_d  = '0;
        cnt_d  = '0;
        idle_d = '0;
      end else begin
        idle_d = idle_q + IW'(1);
      end
    end

    case (state_q)
      ST_LOCKED: begin
        if (io.door_alarm) begin
          // The alarm wins over a same-cycle final digit, which is thrown away.
          state_d = ST_ALARM;
          buf_d   = '0;
          cnt_d   = '0;
          idle_d  = '0;
        end else if (code_done) begin
          if (code_match) begin
            state_d     = ST_UNLOCKED;
            unlock_ok_d = 1'b1;
            fails_d     = '0;
            relock_d    = '0;
          end else begin
            attempt_fail_d = 1'b1;
            if (fails_q >= FW'(MAX_FAILS - 1)) begin
              state_d = ST_LOCKOUT;
              fails_d = '0;
              lkout_d = '0;
            end else begin
              fails_d = fails_q + FW'(1);
            end
          end
        end
      end

      ST_UNLOCKED: begin
        if (!io.magnetic_sensor) begin
          relock_d = '0;
        end else if (io.lock_cmd || (relock_q >= RW'(AUTO_RELOCK - 1))) begin
          state_d  = ST_LOCKED;
          relock_d = '0;
        end else begin
          relock_d = relock_q + RW'(1);
        end
      end

      ST_LOCKOUT: begin
        if (io.door_alarm) begin
          state_d = ST_ALARM;
          lkout_d = '0;
        end else if (lkout_q >= LW'(LOCKOUT_CYCLES - 1)) begin
          state_d = ST_LOCKED;
          lkout_d = '0;
        end else begin
          lkout_d = lkout_q + LW'(1);
        end
      end

      ST_ALARM: begin
        // Wrong codes here are reported but never count toward lockout.
        if (code_done) begin
          if (code_match) begin
            state_d     = ST_UNLOCKED;
            unlock_ok_d = 1'b1;
            fails_d     = '0;
            relock_d    = '0;
          end else begin
            attempt_fail_d = 1'b1;
          end
        end
      end

      default: begin
        state_d = ST_LOCKED;
      end
    endcase
  end

  assign io.locked       = (state_q != ST_UNLOCKED);
  assign io.siren        = (state_q == ST_ALARM);
  assign io.lockout      = (state_q == ST_LOCKOUT);
  assign io.unlock_ok    = unlock_ok_q;
  assign io.attempt_fail = attempt_fail_q;

endmodule

// File: doc/door_lock_controller.md
Name: door_lock_controller

Overview:
- Keypad-driven lock controller that drives the `locked` input of the door monitor and consumes its `alarm` output.
- Collects a fixed-length digit code and unlocks on a match.
- Re-locks automatically or on command, locks out the keypad after repeated wrong codes, and latches the door alarm into a siren until a correct code is entered.
- Sits between the home keypad and the door monitor in the smart-home top level.

Parameters:
- CODE_DIGITS, 4, number of digits per code entry
- SECRET, 16'h1234, code; first entered digit is the MS nibble (keys 1,2,3,4 match)
- MAX_FAILS, 3, consecutive wrong codes that trigger lockout
- LOCKOUT_CYCLES, 16, lockout duration in clk cycles
- AUTO_RELOCK, 20, cycles of continuously closed door in UNLOCKED before auto re-lock
- ENTRY_TIMEOUT, 10, idle cycles mid-entry before the partial code is discarded

Ports:
- clk  input  1  system clock, all state updates on rising edge
- reset  input  1  asynchronous, active-high reset
- key_valid  input  1  one-cycle strobe: key_digit is valid this cycle
- key_digit  input  4  keypad digit 0-9 (values 10-15 accepted as digits, never match unless in SECRET)
- lock_cmd  input  1  manual re-lock button, level-sampled
- magnetic_sensor  input  1  1 = door closed, 0 = door open
- door_alarm  input  1  alarm from door monitor
- locked  output  1  lock drive to door monitor, 1 = locked
- siren  output  1  alarm siren
- lockout  output  1  keypad lockout indicator
- unlock_ok  output  1  one-cycle pulse on successful unlock
- attempt_fail  output  1  one-cycle pulse on wrong complete code

Behaviour:
- Reset (async, immediate):
  - State LOCKED; locked=1, siren=0, lockout=0, unlock_ok=0, attempt_fail=0.
  - Digit buffer, digit count, fail count and all timers = 0.
- States: LOCKED, UNLOCKED, LOCKOUT, ALARM.
  - locked=1 in every state except UNLOCKED.
  - siren=1 only in ALARM; lockout=1 only in LOCKOUT.
- Digit entry (LOCKED and ALARM only):
  - Each key_valid shifts key_digit into a 4*CODE_DIGITS buffer from the LSB side and increments the count.
  - The edge sampling the CODE_DIGITS-th digit compares {buffer, key_digit} to SECRET.
  - Outputs reflect the result after that same edge (1-cycle latency from the final strobe). Buffer and count clear.
  - key_valid is ignored in UNLOCKED and LOCKOUT.
- Entry timeout:
  - When count>0, the idle counter increments each cycle without key_valid.
  - At ENTRY_TIMEOUT the buffer and count clear. This is not a failure and gives no pulse.
- LOCKED:
  - Match -> UNLOCKED, unlock_ok pulse, fail count cleared.
  - Mismatch -> attempt_fail pulse, fail count +1.
  - If the fail count reaches MAX_FAILS -> LOCKOUT, fail count cleared.
  - door_alarm=1 -> ALARM. This has priority over a same-cycle final digit: the digit is discarded and the buffer cleared.
- UNLOCKED:
  - The relock timer counts while magnetic_sensor=1 and resets to 0 whenever magnetic_sensor=0.
  - When the timer reaches AUTO_RELOCK -> LOCKED.
  - lock_cmd=1 with magnetic_sensor=1 -> LOCKED on the next edge.
  - lock_cmd with the door open is ignored.
  - door_alarm is ignored.
- LOCKOUT:
  - The timer counts LOCKOUT_CYCLES, then -> LOCKED.
  - door_alarm=1 -> ALARM immediately; lockout clears and the timer resets.
- ALARM:
  - siren stays 1 regardless of door_alarm deasserting.
  - Correct code -> UNLOCKED, siren=0, unlock_ok pulse, fail count cleared.
  - Wrong codes pulse attempt_fail but do not increment the fail count and never cause LOCKOUT.
- Pulses:
  - unlock_ok and attempt_fail are never both 1.
  - Each is high for exactly one cycle.
- Counter widths: sized by $clog2(param+1). Counters saturate, never wrap.

Test Plan:
- Reset, then key_valid digits 1,2,3,4 on non-consecutive cycles -> after the 4th edge locked=0, unlock_ok=1 for one cycle.
- In UNLOCKED, magnetic_sensor=1 held 20 cycles -> locked=1. Repeat with magnetic_sensor=0 at cycle 10 -> timer restarts, re-lock 20 cycles after door closes. lock_cmd with door closed -> locked=1 on the next edge.
- Enter 1,1,1,1 three times -> three attempt_fail pulses, lockout=1 after the 3rd. key_valid during lockout is ignored. After 16 cycles lockout=0 and code 1,2,3,4 unlocks.
- In LOCKED, pulse door_alarm -> siren=1 and stays after door_alarm drops. Code 9,9,9,9 -> attempt_fail pulse, siren stays 1, no lockout. Code 1,2,3,4 -> siren=0, locked=0.
- Enter 1,2 then idle 10 cycles, then 3,4,1,2 -> no unlock, attempt_fail pulse; the partial entry was discarded.
- Assert reset mid-entry (2 digits) and mid-ALARM -> all outputs return to reset values immediately, without waiting for a clock edge. Then 3,4 alone does not unlock.
